// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_rx_tx block: FSM state encoding,
// data width and the minimum bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int          UART_DATA_W     = 8;
  localparam logic [31:0] UART_MIN_PERIOD = 32'd2;

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < UART_MIN_PERIOD) ? UART_MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable 32-bit down-counter. tick is high in the cycle the count reaches 1,
// so a load of N produces a tick N cycles after the loading edge.
module uart_bit_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        tick
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= 32'd0;
    else if (load)
      count <= load_val;
    else if (count != 32'd0)
      count <= count - 32'd1;
  end

  assign tick = (count == 32'd1);

endmodule

// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART: independent receive and transmit FSMs, runtime bit period.
// Optional macro UART_FRAME_CHECK_EN discards frames whose stop bit samples as 0.
module uart_rx_tx
  import uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            period,
  input  logic                   rx,
  output logic                   out_sync,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   tx,
  input  logic                   in_sync,
  input  logic [UART_DATA_W-1:0] in_data,
  output logic                   tx_busy,
  output logic [1:0]             rx_state_dbg,
  output logic [1:0]             tx_state_dbg
);

  // Strobe handshake: out_sync / in_sync are single-cycle pulses with the data
  // valid in the same cycle; in_sync is dropped (not queued) while tx_busy is high.

  uart_state_t rx_state, tx_state;
  logic [31:0] period_c, rx_p, tx_p;
  logic        rx_s1, rx_s, rx_prev, rx_fall;
  logic        rx_load, rx_tick, tx_load, tx_tick;
  logic [31:0] rx_load_val, tx_load_val;
  logic [2:0]  rx_bit, tx_bit;
  logic [UART_DATA_W-1:0] rx_shift, tx_shift;

  assign period_c     = clamp_period(period);
  assign rx_fall      = rx_prev & ~rx_s;
  assign rx_state_dbg = rx_state;
  assign tx_state_dbg = tx_state;

  always_ff @(posedge clk) begin
    if (rst)
      {rx_prev, rx_s, rx_s1} <= 3'b111;
    else
      {rx_prev, rx_s, rx_s1} <= {rx_s, rx_s1, rx};
  end

  // Receiver timer starts with a half period so every later tick lands mid-bit.
  assign rx_load     = (rx_state == IDLE) ? rx_fall : rx_tick;
  assign rx_load_val = (rx_state == IDLE) ? {1'b0, period_c[31:1]} : rx_p;

  uart_bit_timer u_rx_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_load),
    .load_val (rx_load_val),
    .tick     (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_p     <= UART_MIN_PERIOD;
      rx_bit   <= 3'd0;
      rx_shift <= '0;
      out_data <= '0;
      out_sync <= 1'b0;
    end else begin
      out_sync <= 1'b0;
      case (rx_state)
        IDLE: if (rx_fall) begin
          rx_p     <= period_c;
          rx_state <= START;
        end
        START: if (rx_tick) begin
          rx_bit   <= 3'd0;
          rx_state <= rx_s ? IDLE : DATA;
        end
        DATA: if (rx_tick) begin
          rx_shift <= {rx_s, rx_shift[UART_DATA_W-1:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7)
            rx_state <= STOP;
        end
        STOP: if (rx_tick) begin
`ifdef UART_FRAME_CHECK_EN
          if (rx_s) begin
            out_data <= rx_shift;
            out_sync <= 1'b1;
          end
`else
          out_data <= rx_shift;
          out_sync <= 1'b1;
`endif
          rx_state <= IDLE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  assign tx_load     = (tx_state == IDLE) ? in_sync : tx_tick;
  assign tx_load_val = (tx_state == IDLE) ? period_c : tx_p;

  uart_bit_timer u_tx_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (tx_load_val),
    .tick     (tx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_p     <= UART_MIN_PERIOD;
      tx_bit   <= 3'd0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: if (in_sync) begin
          tx_shift <= in_data;
          tx_p     <= period_c;
          tx       <= 1'b0;
          tx_busy  <= 1'b1;
          tx_state <= START;
        end
        START: if (tx_tick) begin
          tx       <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[UART_DATA_W-1:1]};
          tx_bit   <= 3'd0;
          tx_state <= DATA;
        end
        DATA: if (tx_tick) begin
          if (tx_bit == 3'd7) begin
            tx       <= 1'b1;
            tx_state <= STOP;
          end else begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[UART_DATA_W-1:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end
        STOP: if (tx_tick) begin
          tx_busy  <= 1'b0;
          tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Directed bench for uart_rx_tx: echo, glitch, framing, busy drop,
// back-to-back/boundary periods and reset mid-frame.
module tb_uart_rx_tx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] period = 32'd512;
  logic        rx = 1'b1;
  logic        drv_sync = 1'b0;
  logic [7:0]  drv_data = 8'h00;
  logic        echo_en = 1'b0;
  logic        in_sync;
  logic [7:0]  in_data;
  logic        out_sync, tx, tx_busy;
  logic [7:0]  out_data;
  logic [1:0]  rx_state_dbg, tx_state_dbg;

  assign in_sync = echo_en ? out_sync : drv_sync;
  assign in_data = echo_en ? out_data : drv_data;

  uart_rx_tx dut (
    .clk          (clk),
    .rst          (rst),
    .period       (period),
    .rx           (rx),
    .out_sync     (out_sync),
    .out_data     (out_data),
    .tx           (tx),
    .in_sync      (in_sync),
    .in_data      (in_data),
    .tx_busy      (tx_busy),
    .rx_state_dbg (rx_state_dbg),
    .tx_state_dbg (tx_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int sync_cnt = 0, last_sync_cyc = 0, busy_cyc = 0;
  int n_tests = 0, n_fail = 0;

  always @(negedge clk) begin
    if (out_sync) begin
      got_q.push_back(out_data);
      sync_cnt++;
      last_sync_cyc = cyc;
    end
    if (tx_busy) busy_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int p);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      step(p);
    end
    rx = 1'b1;
  endtask

  task automatic pulse_tx(input logic [7:0] b);
    drv_data = b;
    drv_sync = 1'b1;
    step(1);
    drv_sync = 1'b0;
  endtask

  task automatic decode_tx(input int p, output logic [9:0] b);
    int n;
    n = 0;
    b = '1;
    @(negedge clk);
    while (tx !== 1'b0 && n < 12 * p) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", tx, 0);
    repeat (p / 2) @(negedge clk);
    b[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (p) @(negedge clk);
      b[i] = tx;
    end
  endtask

  task automatic wait_idle(input int p);
    int n;
    n = 0;
    while (tx_busy === 1'b1 && n < 20 * p) begin
      step(1);
      n++;
    end
    check("tx_busy_drop", tx_busy, 0);
  endtask

  logic [9:0] bits;
  logic [7:0] exp_od;
  int k, cnt0, low_cnt;
  int plist[3] = '{8, 2, 0};

  initial begin
    // reset state
    step(3);
    check("rst_tx", tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_out_sync", out_sync, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_rx_state", rx_state_dbg, IDLE);
    check("rst_tx_state", tx_state_dbg, IDLE);
    rst = 1'b0;
    step(2);

    // nominal echo, P=512, byte 0x56
    period = 32'd512;
    echo_en = 1'b1;
    busy_cyc = 0;
    k = cyc;
    exp_q.push_back(8'h56);
    fork
      send_rx(8'h56, 1'b1, 512);
      decode_tx(512, bits);
    join
    check("echo_sync_cycle", last_sync_cyc, k + 3 + 256 + 9 * 512);
    check_rx("echo_rx");
    check("echo_tx_start", bits[0], 0);
    check("echo_tx_data", bits[8:1], 8'h56);
    check("echo_tx_stop", bits[9], 1);
    wait_idle(512);
    check("echo_busy_cycles", busy_cyc, 5120);
    echo_en = 1'b0;
    step(10);

    // glitch: rx low for 100 cycles
    cnt0 = sync_cnt;
    rx = 1'b0;
    step(100);
    rx = 1'b1;
    step(50);
    check("glitch_in_start", rx_state_dbg, START);
    step(200);
    check("glitch_back_idle", rx_state_dbg, IDLE);
    step(5200);
    check("glitch_no_sync", sync_cnt - cnt0, 0);
    check_rx("glitch_rx");

    // framing error: 0xA5 with stop bit 0
    period = 32'd16;
    cnt0 = sync_cnt;
`ifdef UART_FRAME_CHECK_EN
    exp_od = 8'h56;
`else
    exp_od = 8'hA5;
    exp_q.push_back(8'hA5);
`endif
    send_rx(8'hA5, 1'b0, 16);
    step(40);
    check("frame_out_data", out_data, exp_od);
    check_rx("frame_rx");

    // busy drop: second request at +3000 cycles is ignored
    period = 32'd512;
    busy_cyc = 0;
    pulse_tx(8'h11);
    check("busy_tx_fall", tx, 0);
    check("busy_tx_busy_rise", tx_busy, 1);
    fork
      begin
        step(2999);
        pulse_tx(8'h22);
      end
      decode_tx(512, bits);
    join
    check("busy_frame", bits, {1'b1, 8'h11, 1'b0});
    wait_idle(512);
    check("busy_cycles", busy_cyc, 5120);
    low_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      step(1);
      if (tx !== 1'b1) low_cnt++;
    end
    check("busy_no_second_frame", low_cnt, 0);
    check("busy_tx_state_idle", tx_state_dbg, IDLE);

    // back-to-back 0x00 then 0xFF at several periods, including clamped ones
    foreach (plist[j]) begin
      int pe;
      pe = (plist[j] < 2) ? 2 : plist[j];
      period = plist[j];
      cnt0 = sync_cnt;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_rx(8'h00, 1'b1, pe);
      send_rx(8'hFF, 1'b1, pe);
      step(4 * pe + 10);
      check("b2b_pulses", sync_cnt - cnt0, 2);
      check_rx("b2b_rx");
    end

    // reset during data bit 3 of both paths
    period = 32'd16;
    cnt0 = sync_cnt;
    pulse_tx(8'h3C);
    bits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = bits[i];
      step(16);
    end
    rx = bits[4];
    step(8);
    check("mid_rx_in_data", rx_state_dbg, DATA);
    check("mid_tx_in_data", tx_state_dbg, DATA);
    rst = 1'b1;
    rx = 1'b1;
    step(1);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_tx_busy", tx_busy, 0);
    check("mid_rst_rx_state", rx_state_dbg, IDLE);
    check("mid_rst_tx_state", tx_state_dbg, IDLE);
    rst = 1'b0;
    step(200);
    check("mid_rst_no_sync", sync_cnt - cnt0, 0);
    check("mid_rst_tx_idle", tx, 1);
    exp_q.push_back(8'h9A);
    send_rx(8'h9A, 1'b1, 16);
    step(30);
    check_rx("after_rst_rx");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
